// File: rtl/rs_bank_sequencer_if.sv
// rs_bank_sequencer_if: bundles the requester handshake and RS-bank drive/readback signals.
// Latency: none, wires only.
// Backpressure: requesters hold reqN until gntN; the sequencer samples requests only while idle.
// Signals: req/op/mask per requester, gnt/done/err per requester, rs_R/rs_S/rs_enable to the bank,
//          q_in from the bank, busy status.
// master = requesters + bank model side, slave = rs_bank_sequencer.
interface rs_bank_sequencer_if #(
  parameter int WIDTH = 4
);
  logic             req0;
  logic             op0;
  logic [WIDTH-1:0] mask0;
  logic             req1;
  logic             op1;
  logic [WIDTH-1:0] mask1;
  logic             gnt0;
  logic             gnt1;
  logic             done0;
  logic             done1;
  logic             err0;
  logic             err1;
  logic [WIDTH-1:0] rs_R;
  logic [WIDTH-1:0] rs_S;
  logic             rs_enable;
  logic [WIDTH-1:0] q_in;
  logic             busy;

  modport master (
    output req0, op0, mask0, req1, op1, mask1, q_in,
    input  gnt0, gnt1, done0, done1, err0, err1, rs_R, rs_S, rs_enable, busy
  );

  modport slave (
    input  req0, op0, mask0, req1, op1, mask1, q_in,
    output gnt0, gnt1, done0, done1, err0, err1, rs_R, rs_S, rs_enable, busy
  );
endinterface

// File: rtl/rs_bank_sequencer.sv
// rs_bank_sequencer: round-robin arbiter and write sequencer for one shared bank of RS flip-flops.
// Latency: gnt in the cycle after the sampling edge t; done in cycle t+STROBE_CYCLES+2; idle again at t+STROBE_CYCLES+3.
// Backpressure: requests are sampled only in IDLE; a held req waits, and one idle cycle separates transactions.
// Ports: clk (rising edge), reset (synchronous, active-high), bus (slave modport of rs_bank_sequencer_if).
// Optional: define RS_READBACK_CHECK_EN to compare the bank's Q against the written value and pulse err with done;
//           without it err0/err1 stay 0 and q_in is ignored.
module rs_bank_sequencer #(
  parameter int WIDTH         = 4,
  parameter int STROBE_CYCLES = 1   // legal 1..15
) (
  input  logic               clk,
  input  logic               reset,
  rs_bank_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_DONE
  } state_t;

  localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);

  state_t           r_state;
  logic             r_last_grant;
  logic             r_who;        // 0 = requester 0 owns the current transaction
  logic             r_op;
  logic [WIDTH-1:0] r_mask;
  logic [3:0]       r_cnt;
  logic             r_gnt0;
  logic             r_gnt1;
  logic             r_done0;
  logic             r_done1;
  logic             r_err0;
  logic             r_err1;
  logic [WIDTH-1:0] r_rs_R;
  logic [WIDTH-1:0] r_rs_S;
  logic             r_rs_enable;
  logic             r_busy;

  logic             w_pick1;
  logic             w_op;
  logic [WIDTH-1:0] w_mask;
  logic             w_mismatch;

  // Requester 1 wins when it asks alone, or on a tie when requester 0 was served last.
  assign w_pick1 = bus.req1 & (~bus.req0 | ~r_last_grant);
  assign w_op    = w_pick1 ? bus.op1   : bus.op0;
  assign w_mask  = w_pick1 ? bus.mask1 : bus.mask0;

`ifdef RS_READBACK_CHECK_EN
  // Evaluated in HOLD, so q_in is sampled on the edge that enters DONE.
  assign w_mismatch = |(r_mask & (bus.q_in ^ {WIDTH{r_op}}));
`else
  logic w_unused_readback;
  assign w_mismatch        = 1'b0;
  assign w_unused_readback = ^{bus.q_in, r_op, r_mask};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_who        <= 1'b0;
      r_op         <= 1'b0;
      r_mask       <= '0;
      r_cnt        <= '0;
      r_gnt0       <= 1'b0;
      r_gnt1       <= 1'b0;
      r_done0      <= 1'b0;
      r_done1      <= 1'b0;
      r_err0       <= 1'b0;
      r_err1       <= 1'b0;
      r_rs_R       <= '0;
      r_rs_S       <= '0;
      r_rs_enable  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      // Pulse outputs default low; each is raised only on the edge entering its state.
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_err0  <= 1'b0;
      r_err1  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.req0 | bus.req1) begin
            r_who        <= w_pick1;
            r_last_grant <= w_pick1;
            r_gnt0       <= ~w_pick1;
            r_gnt1       <= w_pick1;
            r_op         <= w_op;
            r_mask       <= w_mask;
            // R and S derive from one op bit, so they can never both be 1.
            r_rs_S       <= w_mask & {WIDTH{w_op}};
            r_rs_R       <= w_mask & ~{WIDTH{w_op}};
            r_busy       <= 1'b1;
            r_state      <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_rs_enable <= 1'b1;
          r_cnt       <= STROBE_LAST;
          r_state     <= ST_STROBE;
        end
        ST_STROBE: begin
          if (r_cnt == 4'd0) begin
            r_rs_enable <= 1'b0;
            r_state     <= ST_HOLD;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_HOLD: begin
          // Enable has been low for a full cycle, so R/S may now be released.
          r_rs_R  <= '0;
          r_rs_S  <= '0;
          r_done0 <= ~r_who;
          r_done1 <= r_who;
          r_err0  <= ~r_who & w_mismatch;
          r_err1  <= r_who & w_mismatch;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt0      = r_gnt0;
  assign bus.gnt1      = r_gnt1;
  assign bus.done0     = r_done0;
  assign bus.done1     = r_done1;
  assign bus.err0      = r_err0;
  assign bus.err1      = r_err1;
  assign bus.rs_R      = r_rs_R;
  assign bus.rs_S      = r_rs_S;
  assign bus.rs_enable = r_rs_enable;
  assign bus.busy      = r_busy;

endmodule

// File: doc/rs_bank_sequencer.md
Name: rs_bank_sequencer

Overview:
- Controller that shares one WIDTH-bit bank of RS flip-flops (per-bit R, S, shared enable; outputs Q/Q_comp) between two requesters.
- Arbitrates set/clear requests round-robin.
- Sequences each granted write as set-up R/S → raise enable → drop enable → release R/S, so the bank never sees R and S changing under an open enable and never sees R=S=1.
- Sits between requesting logic and the FlipFlopRS bank instances; drives their R/S/enable inputs directly and reads back Q.

Parameters:
- WIDTH, 4: number of RS flip-flops in the bank.
- STROBE_CYCLES, 1: cycles enable is held high per transaction (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 request; held until gnt0.
- op0  input  1  requester 0 operation: 1 = set, 0 = clear.
- mask0  input  WIDTH  requester 0 bits to affect.
- req1, op1, mask1  input  1/1/WIDTH  same for requester 1.
- gnt0, gnt1  output  1  one-cycle grant pulse; op/mask captured on that edge.
- done0, done1  output  1  one-cycle completion pulse to the granted requester.
- err0, err1  output  1  readback mismatch pulse, coincident with done (see Optional Feature).
- rs_R  output  WIDTH  R inputs to the bank.
- rs_S  output  WIDTH  S inputs to the bank.
- rs_enable  output  1  shared enable to the bank.
- q_in  input  WIDTH  Q outputs fed back from the bank.
- busy  output  1  high whenever state ≠ IDLE.

Behaviour:
- All outputs are registered.
- Reset: state=IDLE, all outputs 0, last_grant=1, so requester 0 wins the first tie.
- States: IDLE → SETUP → STROBE → HOLD → DONE → IDLE.
- IDLE:
  - Samples req0/req1.
  - Only one asserted: grant it.
  - Both asserted: grant the requester ≠ last_grant, then update last_grant.
  - On the granting edge: gnt_x=1 for that cycle; latch op and mask; rs_S = mask & {WIDTH{op}}; rs_R = mask & ~{WIDTH{op}}; go to SETUP.
- SETUP: rs_enable=0; R/S held stable one full cycle; go to STROBE.
- STROBE:
  - rs_enable=1 for exactly STROBE_CYCLES cycles, counted by an internal 4-bit counter.
  - R/S held.
  - Then go to HOLD.
- HOLD: rs_enable=0; R/S still held one cycle; go to DONE.
- DONE:
  - rs_R=rs_S=0; done_x=1 for one cycle to the granted requester.
  - err_x is valid in the same cycle.
  - Go to IDLE.
- Latency: with req sampled at edge t, gnt is high in cycle t, done is high in cycle t+STROBE_CYCLES+2, and IDLE is re-entered at edge t+STROBE_CYCLES+3.
- Requests are sampled only in IDLE.
  - A req held during a transaction waits.
  - A req still high after done is a new request and is re-arbitrated.
  - Minimum one IDLE cycle between transactions.
- Invariants, checked by the bench every cycle:
  - (rs_R & rs_S) == 0.
  - rs_R/rs_S change only on edges where rs_enable is 0 before and after the edge.
  - gnt0 & gnt1 == 0, and done0 & done1 == 0.
- mask=0 is legal: the full sequence runs with R=S=0, the bank holds its state, and done still pulses.
- op/mask changes after gnt are ignored.
- Reset mid-transaction: the next edge forces IDLE and all outputs 0; no done/err is issued. The bank keeps whatever value it latched. last_grant returns to 1.

Optional Feature:
- Macro RS_READBACK_CHECK_EN.
- Defined:
  - In DONE, err_x = |(mask_latched & (q_in ^ {WIDTH{op_latched}})).
  - q_in is sampled on the edge entering DONE.
- Undefined:
  - err0/err1 tied to 0.
  - q_in unused; ports remain for a uniform interface.

Test Plan:
- Reset, then req0=1, op0=1, mask0=4'b1010 → gnt0 at edge 1; rs_S=4'b1010, rs_R=0; rs_enable high for one cycle; done0 at gnt+3; bank Q=4'b1010; err0=0.
- Q=4'b1111, req1=1, op1=0, mask1=4'b0110 → rs_R=4'b0110, rs_S=0; Q becomes 4'b1001; done1 pulses; busy low one cycle later.
- req0 and req1 asserted together from reset and held → grant order 0,1,0,1; never two gnts or two dones in one cycle.
- STROBE_CYCLES=3, single request → rs_enable high exactly 3 consecutive cycles; done at gnt+5; R&S==0 throughout.
- reset asserted during STROBE → next cycle rs_enable=0, rs_R=rs_S=0, busy=0, no done; a following req0 is granted normally.
- With RS_READBACK_CHECK_EN, a bench forces q_in bit 1 = 0 on a set with mask=4'b0010 → err pulses with done; without the macro → err stays 0.
